conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Frame sequencer placed in front of `conv_buffer`. It accepts a per-frame configuration and a valid/ready pixel stream, then forwards pixels into `conv_buffer`. It tracks row and column position and raises a window-valid qualifier only for fully in-frame KERNEL_ROW_SIZE×KERNEL_COLUMN_SIZE windows. It applies downstream backpressure by stalling the source, because `conv_buffer` has no stall input.

## Interface
- DATA_WIDTH, 8, pixel width
- BUFFER_LENGTH, 2000, max frame columns; sets CW = $clog2(BUFFER_LENGTH)
- KERNEL_ROW_SIZE, 3, window rows (KR)
- KERNEL_COLUMN_SIZE, 3, window columns (KC)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame start pulse; sampled only in IDLE
- cfg_cols  in  CW  frame columns, latched on accepted start
- cfg_rows  in  CW  frame rows, latched on accepted start
- src_data  in  DATA_WIDTH  pixel
- src_valid  in  1  pixel valid
- src_ready  out  1  pixel accepted when src_valid && src_ready
- buf_in_point  out  DATA_WIDTH  to conv_buffer.in_point; equals src_data
- buf_valid_in  out  1  to conv_buffer.valid_in; equals src_valid && src_ready
- buf_frame_column_size  out  CW  to conv_buffer.frame_column_size; latched cols
- win_valid  out  1  conv_buffer.out_matrix holds a valid window
- win_ready  in  1  downstream consumes window
- win_row, win_col  out  CW  top-left coordinate of the current window
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after the last window is consumed
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - start with cfg_cols >= KC, cfg_rows >= KR, cfg_cols <= BUFFER_LENGTH: latch config, clear counters, go to STREAM.
  - Any other start: cfg_err=1 for one cycle, stay in IDLE.
  - src_ready=0 in IDLE.
- STREAM: src_ready = !(win_valid && !win_ready).
  - Each accepted pixel sits at (row_cnt, col_cnt).
  - col_cnt wraps cols-1→0 and increments row_cnt.
  - Accepting pixel (rows-1, cols-1) moves the FSM to DRAIN.
- Window qualification on accepted pixel at (r, c) with r >= KR-1 and c >= KC-1:
  - Next cycle: win_valid=1, win_row=r-(KR-1), win_col=c-(KC-1).
  - Windows are never qualified from buf valid_out. This excludes row-wrap windows and stale line-buffer data from the previous frame.
- win_valid clears on win_ready unless the same edge qualifies a new window. A simultaneous consume and push is legal because conv_buffer shifts on that edge.
- DRAIN: src_ready=0. On win_valid && win_ready: go to IDLE and pulse frame_done the next cycle.
- start outside IDLE is ignored; no cfg_err.
- Windows per frame = (rows-KR+1)·(cols-KC+1).

## Timing
- Reset values: src_ready=0, buf_valid_in=0, win_valid=0, win_row=0, win_col=0, busy=0, frame_done=0, cfg_err=0, buf_frame_column_size=0, state=IDLE.
- buf_* are combinational pass-through: zero latency.
- win_valid, win_row and win_col rise one cycle after the qualifying push.
- start→src_ready high: 1 cycle.
- frame_done rises the cycle after the final consume. busy falls on the same edge.
- An asynchronous reset mid-frame aborts immediately; no frame_done. The conv_buffer contents are stale but harmless, since qualification is counter-based.

## Configuration
- CONV_WINDOW_CTRL_ABORT_EN defined: adds input `abort`.
  - abort=1 in STREAM or DRAIN: next edge goes to IDLE, clears win_valid, src_ready=0.
  - No frame_done is pulsed on abort.
  - abort has priority over a simultaneous win_ready or push.
- Undefined: no `abort` port; a frame ends only by completion or rst_n.

## Structure
- Package `conv_pkg`: state enum (IDLE/STREAM/DRAIN) and the CW width localparam function.
- Sub-module `conv_pos_counter`:
  - Column/row counter with wrap.
  - Outputs row, col, last_pixel and in_window flags.
  - Instantiated once.
- Top-level holds the FSM and window register.

## Test plan
- 6×6 frame, pixels 1..36, win_ready=1:
  - First win_valid one cycle after pixel 15, win_row=0, win_col=0.
  - Last window after pixel 36 at (3,3).
  - 16 windows total.
  - frame_done one cycle after the last consume.
- Same frame with win_ready=0 for 5 cycles at the first window:
  - src_ready=0, no buf_valid_in, win_row/win_col held.
  - Resume with zero lost pixels.
- start with cfg_cols=2, cfg_rows=6: cfg_err pulse, busy stays 0, src_ready stays 0.
- Two back-to-back 6×6 frames, the second started in the frame_done cycle:
  - The second frame's first window appears after its 15th pixel.
  - No window from mixed-frame data.
- rst_n low after pixel 20: all outputs at reset values; no frame_done; a new frame works normally.
- With CONV_WINDOW_CTRL_ABORT_EN, abort after pixel 16: IDLE next cycle, win_valid=0, no frame_done.

Source files
------------

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution window sequencer.
//   conv_state_e : frame sequencer states (IDLE, STREAM, DRAIN)
//   cw_of()      : coordinate/column-count width for a given line buffer length
// -----------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } conv_state_e;

    // Width of frame column/row counts; never narrower than one bit.
    function automatic int cw_of(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// -----------------------------------------------------------------------------
// conv_pos_counter
// Raster position of the next pixel to be accepted in the current frame.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : restart at (0,0) (frame start)
//   advance       : one pixel accepted at the current position
//   cols, rows    : latched frame dimensions
//   row, col      : position of the pixel that the next accept will take
//   last_pixel    : current position is (rows-1, cols-1)
//   in_window     : a pixel at the current position completes a full window
// -----------------------------------------------------------------------------
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int CW = 11,
    parameter int KR = 3,
    parameter int KC = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic [CW-1:0] cols,
    input  logic [CW-1:0] rows,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last_pixel,
    output logic          in_window
);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] KR_M1 = CW'(KR - 1);
    localparam logic [CW-1:0] KC_M1 = CW'(KC - 1);

    logic end_col;

    assign end_col    = (col == cols - ONE);
    assign last_pixel = end_col && (row == rows - ONE);
    assign in_window  = (row >= KR_M1) && (col >= KC_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (end_col) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv_window_ctrl
// Frame sequencer in front of conv_buffer. Accepts a per-frame configuration,
// forwards a valid/ready pixel stream into conv_buffer and qualifies only
// fully in-frame KERNEL_ROW_SIZE x KERNEL_COLUMN_SIZE windows. Because
// conv_buffer cannot stall, an unconsumed window stalls the pixel source.
//
// Handshakes: a pixel transfers on a cycle where src_valid && src_ready; a
// window is consumed on a cycle where win_valid && win_ready. valid may not
// depend on ready; ready may depend on valid.
//
// Optional feature: define CONV_WINDOW_CTRL_ABORT_EN to add input `abort`,
// which returns STREAM/DRAIN to IDLE on the next edge without frame_done.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, cfg_cols, cfg_rows   : frame start request and dimensions
//   abort                       : (optional) abandon the current frame
//   src_data/src_valid/src_ready: pixel stream input
//   buf_in_point, buf_valid_in,
//   buf_frame_column_size       : drive conv_buffer
//   win_valid, win_ready        : window qualifier handshake
//   win_row, win_col            : top-left coordinate of the current window
//   busy, frame_done, cfg_err   : status
//   state                       : current FSM state (debug)
// -----------------------------------------------------------------------------
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter  int DATA_WIDTH         = 8,
    parameter  int BUFFER_LENGTH      = 2000,
    parameter  int KERNEL_ROW_SIZE    = 3,
    parameter  int KERNEL_COLUMN_SIZE = 3,
    localparam int CW                 = cw_of(BUFFER_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CW-1:0]         cfg_cols,
    input  logic [CW-1:0]         cfg_rows,
`ifdef CONV_WINDOW_CTRL_ABORT_EN
    input  logic                  abort,
`endif
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] buf_in_point,
    output logic                  buf_valid_in,
    output logic [CW-1:0]         buf_frame_column_size,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [CW-1:0]         win_row,
    output logic [CW-1:0]         win_col,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err,
    output conv_state_e           state
);

    localparam int            CWP1     = CW + 1;
    localparam logic [CW-1:0] KR_W     = CW'(KERNEL_ROW_SIZE);
    localparam logic [CW-1:0] KC_W     = CW'(KERNEL_COLUMN_SIZE);
    localparam logic [CW-1:0] KR_M1    = CW'(KERNEL_ROW_SIZE - 1);
    localparam logic [CW-1:0] KC_M1    = CW'(KERNEL_COLUMN_SIZE - 1);
    localparam logic [CW:0]   MAX_COLS = CWP1'(BUFFER_LENGTH);

    conv_state_e   state_q, state_d;
    logic [CW-1:0] cols_q, rows_q;
    logic [CW-1:0] cnt_row, cnt_col;
    logic          cnt_last, cnt_in_win;
    logic          abort_req;
    logic          cfg_ok, accept_start, reject_start;
    logic          push, consume;

`ifdef CONV_WINDOW_CTRL_ABORT_EN
    assign abort_req = abort && (state_q != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign cfg_ok = (cfg_cols >= KC_W) && (cfg_rows >= KR_W) &&
                    ({1'b0, cfg_cols} <= MAX_COLS);

    // A held window means conv_buffer must not shift, so the source stalls.
    assign src_ready = (state_q == STREAM) && !(win_valid && !win_ready) && !abort_req;
    assign push      = src_valid && src_ready;
    assign consume   = win_valid && win_ready;

    assign buf_in_point          = src_data;
    assign buf_valid_in          = push;
    assign buf_frame_column_size = cols_q;
    assign busy                  = (state_q != IDLE);
    assign state                 = state_q;

    conv_pos_counter #(
        .CW (CW),
        .KR (KERNEL_ROW_SIZE),
        .KC (KERNEL_COLUMN_SIZE)
    ) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept_start),
        .advance    (push),
        .cols       (cols_q),
        .rows       (rows_q),
        .row        (cnt_row),
        .col        (cnt_col),
        .last_pixel (cnt_last),
        .in_window  (cnt_in_win)
    );

    // FSM next state
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        reject_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        accept_start = 1'b1;
                        state_d      = STREAM;
                    end else begin
                        reject_start = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (push && cnt_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (consume) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_req) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Configuration, status pulses and the window register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_q     <= '0;
            rows_q     <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            frame_done <= (state_q == DRAIN) && consume && !abort_req;
            cfg_err    <= reject_start;
            if (accept_start) begin
                cols_q <= cfg_cols;
                rows_q <= cfg_rows;
            end
            // Qualification is purely counter-based: the pushed pixel closes a
            // window only when it lies at least KR-1 rows and KC-1 columns in,
            // so row-wrap windows and stale line-buffer data never qualify.
            // A push may coincide with a consume; the push wins.
            if (abort_req) begin
                win_valid <= 1'b0;
            end else if (push && cnt_in_win) begin
                win_valid <= 1'b1;
                win_row   <= cnt_row - KR_M1;
                win_col   <= cnt_col - KC_M1;
            end else if (consume) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_window_ctrl
// Self-checking bench for conv_window_ctrl. A frame-level reference model
// (pixel index -> raster coordinate arithmetic, list of expected windows)
// predicts every output each cycle. Build with CONV_WINDOW_CTRL_ABORT_EN
// defined to also exercise the abort input.
// -----------------------------------------------------------------------------
module tb_conv_window_ctrl;
    import conv_pkg::*;

    localparam int DW = 8;
    localparam int BL = 2000;
    localparam int KR = 3;
    localparam int KC = 3;
    localparam int CW = cw_of(BL);
    localparam int W  = 2 * CW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_cols = '0;
    logic [CW-1:0] cfg_rows = '0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          win_ready = 1'b0;
    logic          abort_in = 1'b0;

    logic          src_ready;
    logic [DW-1:0] buf_in_point;
    logic          buf_valid_in;
    logic [CW-1:0] buf_frame_column_size;
    logic          win_valid;
    logic [CW-1:0] win_row, win_col;
    logic          busy, frame_done, cfg_err;
    conv_state_e   state;

    always #5 clk = ~clk;

    conv_window_ctrl #(
        .DATA_WIDTH         (DW),
        .BUFFER_LENGTH      (BL),
        .KERNEL_ROW_SIZE    (KR),
        .KERNEL_COLUMN_SIZE (KC)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .cfg_cols              (cfg_cols),
        .cfg_rows              (cfg_rows),
`ifdef CONV_WINDOW_CTRL_ABORT_EN
        .abort                 (abort_in),
`endif
        .src_data              (src_data),
        .src_valid             (src_valid),
        .src_ready             (src_ready),
        .buf_in_point          (buf_in_point),
        .buf_valid_in          (buf_valid_in),
        .buf_frame_column_size (buf_frame_column_size),
        .win_valid             (win_valid),
        .win_ready             (win_ready),
        .win_row               (win_row),
        .win_col               (win_col),
        .busy                  (busy),
        .frame_done            (frame_done),
        .cfg_err               (cfg_err),
        .state                 (state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];     // windows still expected this frame, raster order
    bit m_busy, m_wv, m_done, m_err, m_push;
    int m_cols, m_rows, m_pix, m_wr, m_wc, m_frame_wins;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wv = 0; m_done = 0; m_err = 0; m_push = 0;
        m_cols = 0; m_rows = 0; m_pix = 0; m_wr = 0; m_wc = 0; m_frame_wins = 0;
        exp_q.delete();
    endtask

    function automatic bit exp_ready();
        return m_busy && (m_pix < m_cols * m_rows) && !(m_wv && !win_ready) && !abort_in;
    endfunction

    // Compare every DUT output with the model for the current cycle.
    task automatic check_outputs();
        bit rdy;
        rdy = exp_ready();
        check("src_ready", src_ready, rdy);
        check("buf_valid_in", buf_valid_in, src_valid && rdy);
        check("buf_in_point", buf_in_point, src_data);
        check("buf_cols", buf_frame_column_size, m_cols);
        check("win_valid", win_valid, m_wv);
        check("win_row", win_row, m_wr);
        check("win_col", win_col, m_wc);
        check("busy", busy, m_busy);
        check("state_idle", state == IDLE, !m_busy);
        check("frame_done", frame_done, m_done);
        check("cfg_err", cfg_err, m_err);
        if (m_busy && m_wv && win_ready && !abort_in) begin
            if (exp_q.size() == 0) check("window_extra", exp_q.size(), 1);
            else check("window_order", {win_row, win_col}, exp_q.pop_front());
            m_frame_wins++;
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit push, consume, was_drain;
        int r, c;
        push    = src_valid && exp_ready();
        consume = m_wv && win_ready;
        m_push  = push;
        m_done  = 0;
        m_err   = 0;
        if (!m_busy) begin
            if (start) begin
                if (int'(cfg_cols) >= KC && int'(cfg_rows) >= KR && int'(cfg_cols) <= BL) begin
                    m_busy = 1; m_cols = int'(cfg_cols); m_rows = int'(cfg_rows);
                    m_pix = 0; m_frame_wins = 0;
                    exp_q.delete();
                    for (int rr = 0; rr <= m_rows - KR; rr++)
                        for (int cc = 0; cc <= m_cols - KC; cc++)
                            exp_q.push_back({CW'(rr), CW'(cc)});
                end else begin
                    m_err = 1;
                end
            end
        end else if (abort_in) begin
            m_busy = 0; m_wv = 0;
            exp_q.delete();
        end else begin
            was_drain = (m_pix == m_cols * m_rows);
            if (push) begin
                r = m_pix / m_cols;
                c = m_pix % m_cols;
                m_pix++;
                if (r >= KR - 1 && c >= KC - 1) begin
                    m_wv = 1; m_wr = r - (KR - 1); m_wc = c - (KC - 1);
                end else if (consume) begin
                    m_wv = 0;
                end
            end else if (consume) begin
                m_wv = 0;
            end
            if (was_drain && consume) begin
                m_busy = 0; m_done = 1;
            end
        end
    endtask

    // Inputs are applied at posedge+1; outputs are checked at posedge+2.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- driver ----------------
    // mode 0: continuous pixels, win_ready=1
    // mode 1: as mode 0 but the first window is held for 5 cycles
    // mode 2: random src_valid / win_ready / data
    task automatic run_frame(input int cols, input int rows, input int mode, input int stop_after);
        int sent, cyc, stall;
        sent = 0; cyc = 0; stall = 0;
        start = 1; cfg_cols = CW'(cols); cfg_rows = CW'(rows); src_valid = 0;
        step();
        start = 0;
        while (m_busy && cyc < 4000 && !(stop_after >= 0 && sent >= stop_after)) begin
            src_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            src_data  = (mode == 2) ? DW'($urandom_range(0, 255)) : DW'(sent + 1);
            if (mode == 1) begin
                win_ready = !(m_frame_wins == 0 && m_wv && stall < 5);
                if (m_wv && !win_ready) stall++;
            end else if (mode == 2) begin
                win_ready = ($urandom_range(0, 9) < 7);
            end else begin
                win_ready = 1'b1;
            end
            step();
            if (m_push) sent++;
            cyc++;
        end
        src_valid = 0;
        if (stop_after < 0) begin
            check("frame_finished", m_busy, 0);
            check("window_count", m_frame_wins, (rows - KR + 1) * (cols - KC + 1));
            check("windows_left", exp_q.size(), 0);
            check("pixels_sent", sent, rows * cols);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        model_reset();
        #2;
        check_outputs();                      // reset values
        @(posedge clk);
        #1;
        rst_n = 1;
        step();

        // 6x6 frame, pixels 1..36, no backpressure
        run_frame(6, 6, 0, -1);
        step();                               // frame_done pulse
        step();

        // same frame with the first window held for 5 cycles
        run_frame(6, 6, 1, -1);
        step();

        // rejected configurations
        for (int i = 0; i < 3; i++) begin
            start = 1;
            cfg_cols = (i == 0) ? CW'(2) : (i == 1) ? CW'(6) : CW'(BL + 1);
            cfg_rows = (i == 1) ? CW'(2) : CW'(6);
            src_valid = 1;
            step();
            start = 0;
            step();                           // cfg_err pulse, busy/src_ready low
            step();
            src_valid = 0;
        end

        // back-to-back frames: second start lands in the frame_done cycle
        run_frame(6, 6, 0, -1);
        run_frame(6, 6, 0, -1);
        step();

        // asynchronous reset after pixel 20, then a normal frame
        run_frame(6, 6, 0, 20);
        src_valid = 1;
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1;
        src_valid = 0;
        step();
        step();
        run_frame(6, 6, 0, -1);
        step();

        // boundary sizes and randomized frames
        run_frame(KC, KR, 0, -1);
        step();
        run_frame(KC, KR + 2, 2, -1);
        step();
        for (int f = 0; f < 4; f++) begin
            run_frame($urandom_range(KC, 9), $urandom_range(KR, 7), 2, -1);
            step();
        end

`ifdef CONV_WINDOW_CTRL_ABORT_EN
        // abort after pixel 16 with a push and consume pending
        run_frame(6, 6, 0, 16);
        abort_in = 1;
        src_valid = 1;
        win_ready = 1;
        step();
        abort_in = 0;
        src_valid = 0;
        step();
        step();
        run_frame(6, 6, 2, -1);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
